// File: rtl/uart_tx_bridge.sv
// ============================================================================
// uart_tx_bridge : memory-mapped UART registers -> FIFO -> 8N1 TX serialiser
// Revision 1.0
// ============================================================================
`default_nettype none

module uart_tx_bridge #(
  parameter int          DEPTH       = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                io_uart_io_reg,
  input  logic [31:0]                io_uart_csr_reg,
  output logic                       uart_tx,
  output logic                       tx_busy,
  output logic                       fifo_full,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          prev_toggle;
  logic [7:0]    shift_reg, shift_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic [15:0]   baud_cnt, baud_nxt;
  logic [15:0]   div_r, div_nxt;
  logic          tx_nxt;

  logic        tx_enable, ovf_clear, post, push, pop, drop, is_empty;
  logic [15:0] csr_div;
  logic        unused_bits;

  assign tx_enable   = io_uart_csr_reg[0];
  assign ovf_clear   = io_uart_csr_reg[1];
  assign csr_div     = io_uart_csr_reg[31:16];
  assign unused_bits = ^{io_uart_io_reg[31:9], io_uart_csr_reg[15:2]};

  assign is_empty   = (count == '0);
  assign fifo_full  = (count == CW'(DEPTH));
  assign fifo_count = count;
  assign tx_busy    = (state != IDLE) || !is_empty;

  // A toggle edge only counts as a post while enabled; disabled edges are lost.
  assign post = (io_uart_io_reg[8] != prev_toggle) && tx_enable;
  assign push = post && (!fifo_full || pop);
  assign drop = post && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      prev_toggle <= io_uart_io_reg[8];
    end else begin
      prev_toggle <= io_uart_io_reg[8];
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop)           overflow <= 1'b1;
      else if (ovf_clear) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) mem[wr_ptr] <= io_uart_io_reg[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      uart_tx   <= 1'b1;
      shift_reg <= '0;
      bit_idx   <= '0;
      baud_cnt  <= '0;
      div_r     <= DEFAULT_DIV;
    end else begin
      state     <= state_nxt;
      uart_tx   <= tx_nxt;
      shift_reg <= shift_nxt;
      bit_idx   <= bit_nxt;
      baud_cnt  <= baud_nxt;
      div_r     <= div_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shift_nxt = shift_reg;
    bit_nxt   = bit_idx;
    baud_nxt  = baud_cnt;
    div_nxt   = div_r;
    pop       = 1'b0;
    tx_nxt    = 1'b1;
    case (state)
      IDLE: begin
        if (!is_empty && tx_enable) begin
          pop       = 1'b1;
          shift_nxt = mem[rd_ptr];
          div_nxt   = (csr_div != 16'd0) ? csr_div : DEFAULT_DIV;
          baud_nxt  = div_nxt - 16'd1;
          state_nxt = START;
        end
      end
      START: begin
        if (baud_cnt == 16'd0) begin
          baud_nxt  = div_r - 16'd1;
          bit_nxt   = 3'd0;
          state_nxt = DATA;
        end else begin
          baud_nxt = baud_cnt - 16'd1;
        end
      end
      DATA: begin
        if (baud_cnt == 16'd0) begin
          baud_nxt = div_r - 16'd1;
          if (bit_idx == 3'd7) state_nxt = STOP;
          else                 bit_nxt   = bit_idx + 3'd1;
        end else begin
          baud_nxt = baud_cnt - 16'd1;
        end
      end
      STOP: begin
        if (baud_cnt == 16'd0) state_nxt = IDLE;
        else                   baud_nxt  = baud_cnt - 16'd1;
      end
      default: state_nxt = IDLE;
    endcase
    // Line level is registered from the next state so it aligns with the state.
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[bit_nxt];
      default: tx_nxt = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_bridge.sv
// ============================================================================
// tb_uart_tx_bridge : directed bench with a queue-based line model and receiver
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_bridge;

  localparam int          DEPTH       = 8;
  localparam logic [15:0] DEFAULT_DIV = 16'd868;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] io_reg = '0;
  logic [31:0] csr = '0;
  logic        uart_tx, tx_busy, fifo_full, overflow;
  logic [3:0]  fifo_count;

  always #5 clk = ~clk;

  uart_tx_bridge #(.DEPTH(DEPTH), .DEFAULT_DIV(DEFAULT_DIV)) dut (
    .clk             (clk),
    .rst             (rst),
    .io_uart_io_reg  (io_reg),
    .io_uart_csr_reg (csr),
    .uart_tx         (uart_tx),
    .tx_busy         (tx_busy),
    .fifo_full       (fifo_full),
    .fifo_count      (fifo_count),
    .overflow        (overflow)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   model_valid = 1'b0;
  logic tog = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: byte queue for the FIFO, bit queue for the line (front = current cycle).
  logic [7:0] m_q[$];
  bit         m_line[$];
  bit         m_ovf = 1'b0;
  bit         m_prev = 1'b0;

  task automatic model_step();
    bit          tog_in, en, pop, post, set_ovf, v;
    int unsigned d;
    logic [7:0]  b;
    tog_in  = io_reg[8];
    en      = csr[0];
    set_ovf = 1'b0;
    if (!rst) begin
      m_q.delete();
      m_line.delete();
      m_ovf       = 1'b0;
      m_prev      = tog_in;
      model_valid = 1'b1;
      return;
    end
    pop  = (m_line.size() == 0) && (m_q.size() != 0) && en;
    post = (tog_in != m_prev) && en;
    d    = (csr[31:16] != 16'd0) ? int'(csr[31:16]) : int'(DEFAULT_DIV);
    if (m_line.size() != 0) void'(m_line.pop_front());
    if (pop) begin
      b = m_q.pop_front();
      for (int k = 0; k < 10; k++) begin
        v = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
        repeat (d) m_line.push_back(v);
      end
    end
    if (post) begin
      if (m_q.size() < DEPTH) m_q.push_back(io_reg[7:0]);
      else                    set_ovf = 1'b1;
    end
    if (set_ovf)     m_ovf = 1'b1;
    else if (csr[1]) m_ovf = 1'b0;
    m_prev = tog_in;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (model_valid) begin
      check("uart_tx",    uart_tx,    (m_line.size() != 0) ? m_line[0] : 1'b1);
      check("tx_busy",    tx_busy,    (m_line.size() != 0) || (m_q.size() != 0));
      check("fifo_full",  fifo_full,  m_q.size() == DEPTH);
      check("fifo_count", fifo_count, m_q.size());
      check("overflow",   overflow,   m_ovf);
    end
  end

  // Independent line receiver, fixed bit period rx_div.
  bit         rx_en = 1'b0;
  int         rx_div = 4;
  bit         rx_prev = 1'b1;
  logic [7:0] rx_q[$];
  int         rx_starts[$];

  initial forever begin
    logic [7:0] rb;
    @(negedge clk);
    if (rx_en && rx_prev && !uart_tx) begin
      rx_starts.push_back(cyc);
      repeat (rx_div / 2) @(negedge clk);
      for (int j = 0; j < 8; j++) begin
        repeat (rx_div) @(negedge clk);
        rb[j] = uart_tx;
      end
      repeat (rx_div) @(negedge clk);
      check("rx_stop_bit", uart_tx, 1'b1);
      rx_q.push_back(rb);
    end
    rx_prev = uart_tx;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic post(input logic [7:0] b);
    tog    = ~tog;
    io_reg = {23'd0, tog, b};
    tick(1);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (tx_busy && n < bound) begin
      tick(1);
      n++;
    end
    check("drain_timeout", tx_busy, 1'b0);
  endtask

  task automatic low_run(input int bound, output int len);
    len = 0;
    while (uart_tx == 1'b0 && len < bound) begin
      tick(1);
      len++;
    end
  endtask

  initial begin
    logic [39:0] vec;
    int          len;
    int          n;

    // 1: reset state, then one 0x55 frame at div=4
    tick(3);
    check("rst_uart_tx", uart_tx, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_count", fifo_count, 4'd0);
    check("rst_full", fifo_full, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    rst = 1'b1;
    csr = 32'h0004_0001;
    tick(2);
    post(8'h55);
    check("t1_count_c1", fifo_count, 4'd1);
    check("t1_tx_c1", uart_tx, 1'b1);
    tick(1);
    for (int i = 0; i < 40; i++) begin
      vec[39-i] = uart_tx;
      if (i < 39) tick(1);
    end
    check("t1_frame_0x55", vec, 40'h0F0F0F0F0F);
    check("t1_busy_c41", tx_busy, 1'b1);
    tick(1);
    check("t1_busy_c42", tx_busy, 1'b0);

    // 2: ten back-to-back posts, one dropped
    rx_div = 4;
    rx_q.delete();
    rx_starts.delete();
    rx_en = 1'b1;
    for (int i = 0; i < 10; i++) post(8'(i));
    check("t2_full", fifo_full, 1'b1);
    check("t2_ovf", overflow, 1'b1);
    check("t2_count", fifo_count, 4'd8);
    wait_idle(2000);
    tick(5);
    check("t2_rx_count", rx_q.size(), 9);
    for (int i = 0; i < rx_q.size(); i++) check("t2_rx_byte", rx_q[i], 8'(i));
    if (rx_starts.size() >= 2) check("t2_period", rx_starts[1] - rx_starts[0], 41);
    else                       check("t2_period_missing", rx_starts.size(), 2);
    rx_en = 1'b0;

    // 3: overflow clear, and set beating clear
    csr = 32'h0004_0003;
    tick(1);
    csr = 32'h0004_0001;
    check("t3_ovf_cleared", overflow, 1'b0);
    for (int i = 0; i < 9; i++) post(8'h10 + 8'(i));
    check("t3_full", fifo_full, 1'b1);
    check("t3_ovf_still0", overflow, 1'b0);
    csr = 32'h0004_0003;
    post(8'hEE);
    csr = 32'h0004_0001;
    check("t3_set_wins", overflow, 1'b1);
    check("t3_count", fifo_count, 4'd8);
    tick(1);
    check("t3_sticky", overflow, 1'b1);
    csr = 32'h0004_0003;
    tick(1);
    csr = 32'h0004_0001;
    check("t3_ovf_cleared2", overflow, 1'b0);
    wait_idle(1000);

    // 4: default divisor, mid-frame divisor change
    csr = 32'h0000_0001;
    tick(1);
    post(8'h3C);
    post(8'hC3);
    csr = 32'h0002_0001;
    low_run(5000, len);
    check("t4_low_run_868", len, 2604);
    n = 0;
    while (fifo_count != 0 && n < 10000) begin
      tick(1);
      n++;
    end
    check("t4_second_popped", fifo_count, 4'd0);
    low_run(100, len);
    check("t4_low_run_2", len, 2);
    wait_idle(200);

    // 5: toggles while disabled are lost
    csr = 32'h0004_0000;
    tick(1);
    for (int i = 0; i < 3; i++) begin
      tog    = ~tog;
      io_reg = {23'd0, tog, 8'h3F};
      tick(2);
    end
    check("t5_count", fifo_count, 4'd0);
    check("t5_tx", uart_tx, 1'b1);
    check("t5_busy", tx_busy, 1'b0);
    csr = 32'h0004_0001;
    tick(2);
    rx_div = 4;
    rx_q.delete();
    rx_en = 1'b1;
    post(8'hA5);
    wait_idle(200);
    tick(3);
    check("t5_rx_count", rx_q.size(), 1);
    if (rx_q.size() != 0) check("t5_rx_byte", rx_q[0], 8'hA5);
    rx_en = 1'b0;

    // 6: reset during data bit 3, toggle held high across release
    post(8'h96);
    post(8'h11);
    tick(17);
    rst    = 1'b0;
    tog    = 1'b1;
    io_reg = {23'd0, 1'b1, 8'h77};
    tick(1);
    check("t6_tx_abort", uart_tx, 1'b1);
    check("t6_count_rst", fifo_count, 4'd0);
    check("t6_busy_rst", tx_busy, 1'b0);
    tick(1);
    rst = 1'b1;
    tick(5);
    check("t6_no_post_count", fifo_count, 4'd0);
    check("t6_no_post_busy", tx_busy, 1'b0);
    check("t6_no_post_tx", uart_tx, 1'b1);
    check("t6_ovf", overflow, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
